rip_bp_counter_table: RTL and testbench
=======================================

RIP_BP_COUNTER_TABLE -- requirements
Module: rip_bp_counter_table

Interface
REQ-001 SHALL have parameter INIT_WEIGHT, default WEAKLY_UNTAKEN (bp_weight_t), value written to every entry on reset sweep.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pred_valid  input  1  prediction lookup request.
REQ-005 SHALL have port pred_index  input  bp_index_t  lookup index (PC bits or gshare hash, computed upstream).
REQ-006 SHALL have port pred_ready  output  1  lookup accepted this cycle.
REQ-007 SHALL have port pred_out_valid  output  1  lookup result valid.
REQ-008 SHALL have port pred_taken  output  1  predicted direction (counter MSB).
REQ-009 SHALL have port pred_weight  output  bp_weight_t  full counter value looked up.
REQ-010 SHALL have port update_valid  input  1  resolved-branch training request.
REQ-011 SHALL have port update_index  input  bp_index_t  entry to train.
REQ-012 SHALL have port update_taken  input  1  resolved direction.
REQ-013 SHALL have port init_done  output  1  table initialised, normal operation.

Function
REQ-014 SHALL hold 2**TABLE_DEPTH entries of bp_weight_t (2-bit counters).
REQ-015 SHALL implement FSM states INIT and RUN; INIT writes INIT_WEIGHT to entry 0..2**TABLE_DEPTH-1, one per cycle, then enters RUN.
REQ-016 SHALL take exactly 2**TABLE_DEPTH cycles in INIT after rst deasserts; init_done rises the following cycle and stays high until rst.
REQ-017 SHALL drive pred_ready = init_done; lookups with pred_ready low are dropped, with no output.
REQ-018 SHALL return lookup result one cycle after acceptance: pred_out_valid high exactly one cycle per accepted request; back-to-back lookups sustain one per cycle.
REQ-019 SHALL hold pred_taken/pred_weight stable while pred_out_valid is low.
REQ-020 SHALL train on update_valid in RUN: taken increments, not-taken decrements, saturating at STRONGLY_TAKEN (11) and STRONGLY_UNTAKEN (00); no wrap.
REQ-021 SHALL write the updated entry at the clock edge where update_valid is sampled (single-cycle read-modify-write).
REQ-022 SHALL ignore update_valid during INIT (no write, no sweep disturbance).
REQ-023 SHALL apply lookup and update in the same cycle to different indices independently.

Reset
REQ-024 SHALL on rst: state=INIT, sweep counter=0, init_done=0, pred_out_valid=0, pred_taken=0, pred_weight=STRONGLY_UNTAKEN.
REQ-025 SHALL abort any in-progress INIT or pending lookup when rst asserts mid-operation, restarting the sweep from entry 0.

Configuration
REQ-026 SHALL with BP_FWD_EN defined, forward a same-cycle update: a lookup and update on the same index return the post-update counter.
REQ-027 SHALL without BP_FWD_EN return the pre-update counter in that case; the update still commits.

Structure
REQ-028 SHALL import bp_index_t, bp_weight_t, TABLE_DEPTH, TABLE_WIDTH from rip_branch_predictor_const; SHALL add a new shared function sat_update(bp_weight_t, logic) to that package.
REQ-029 SHALL place the saturating-counter RAM in sub-module rip_bp_counter_ram (1 read, 1 write port, registered read).

Verification
REQ-030 SHALL cover reset: rst pulse, TABLE_DEPTH=4 -> init_done rises at cycle 17 after deassert; lookups before then produce no pred_out_valid.
REQ-031 SHALL cover saturation up: 5 taken updates to index 3 -> lookup returns 11, pred_taken=1.
REQ-032 SHALL cover saturation down: 3 not-taken updates to index 5 -> lookup returns 00, pred_taken=0.
REQ-033 SHALL cover collision: entry 7=01, update taken + lookup index 7 same cycle -> 10 with BP_FWD_EN, 01 without; next lookup -> 10 in both builds.
REQ-034 SHALL cover rst mid-INIT at cycle 6 -> sweep restarts, init_done delayed to cycle 17 after second deassert, all entries read 01.
REQ-035 SHALL cover streaming: 16 consecutive lookups -> 16 consecutive pred_out_valid cycles, each result one cycle after its request.

Source files
------------

// File: rtl/rip_branch_predictor_const.sv
// rip_branch_predictor_const: shared branch-predictor types, table geometry and the saturating-counter update
package rip_branch_predictor_const;
    localparam int TABLE_DEPTH = 4;
    localparam int TABLE_WIDTH = 2;
    typedef logic [TABLE_DEPTH-1:0] bp_index_t;
    typedef enum logic [TABLE_WIDTH-1:0] {
        STRONGLY_UNTAKEN = 2'b00,
        WEAKLY_UNTAKEN   = 2'b01,
        WEAKLY_TAKEN     = 2'b10,
        STRONGLY_TAKEN   = 2'b11
    } bp_weight_t;
    function automatic bp_weight_t sat_update(bp_weight_t w, logic taken);
        return taken ? ((w == STRONGLY_TAKEN) ? w : bp_weight_t'(w + 2'd1))
                     : ((w == STRONGLY_UNTAKEN) ? w : bp_weight_t'(w - 2'd1));
    endfunction
endpackage

// File: rtl/rip_bp_counter_ram.sv
// rip_bp_counter_ram: 2-bit counter RAM, registered read port, read-modify-write port
//   clk, rst             clock, async active-high reset (read register only)
//   i_re/i_raddr         read request; o_rdata updates the cycle after, holds otherwise
//   i_we/i_waddr         write request
//   i_wset/i_wdata       1: store i_wdata verbatim (init sweep); 0: saturating train by i_wtaken
//   o_rdata              registered read data
// Build option BP_FWD_EN: a same-cycle read of the entry being written returns the new value.
module rip_bp_counter_ram
    import rip_branch_predictor_const::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_re,
    input  bp_index_t  i_raddr,
    input  logic       i_we,
    input  bp_index_t  i_waddr,
    input  logic       i_wset,
    input  bp_weight_t i_wdata,
    input  logic       i_wtaken,
    output bp_weight_t o_rdata
);
    bp_weight_t r_mem [0:(1<<TABLE_DEPTH)-1];
    bp_weight_t r_rdata;
    bp_weight_t w_wnext;
    bp_weight_t w_rnext;
    assign w_wnext = i_wset ? i_wdata : sat_update(r_mem[i_waddr], i_wtaken);
`ifdef BP_FWD_EN
    assign w_rnext = (i_we && i_waddr == i_raddr) ? w_wnext : r_mem[i_raddr];
`else
    assign w_rnext = r_mem[i_raddr];
`endif
    assign o_rdata = r_rdata;
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= w_wnext;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rdata <= STRONGLY_UNTAKEN;
        else if (i_re) r_rdata <= w_rnext;
    end
endmodule

// File: rtl/rip_bp_counter_table.sv
// rip_bp_counter_table: branch-predictor 2-bit counter table with init sweep, lookup and training
//   clk, rst                         clock, async active-high reset
//   pred_valid/pred_index            lookup request, accepted when pred_ready
//   pred_ready                       equals init_done
//   pred_out_valid                   one-cycle pulse, one cycle after each accepted lookup
//   pred_taken/pred_weight           looked-up counter MSB / full value, held between results
//   update_valid/index/taken         resolved-branch training (ignored during INIT)
//   init_done                        high once every entry holds INIT_WEIGHT
// Build option BP_FWD_EN: same-cycle lookup/update on one index returns the post-update counter.
module rip_bp_counter_table
    import rip_branch_predictor_const::*;
#(
    parameter bp_weight_t INIT_WEIGHT = WEAKLY_UNTAKEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pred_valid,
    input  bp_index_t  pred_index,
    output logic       pred_ready,
    output logic       pred_out_valid,
    output logic       pred_taken,
    output bp_weight_t pred_weight,
    input  logic       update_valid,
    input  bp_index_t  update_index,
    input  logic       update_taken,
    output logic       init_done
);
    localparam logic INIT = 1'b0;
    localparam logic RUN  = 1'b1;
    logic       r_state;
    bp_index_t  r_sweep;
    logic       r_out_valid;
    logic       w_init;
    logic       w_accept;
    bp_weight_t w_rdata;
    assign w_init         = (r_state == INIT);
    assign init_done      = ~w_init;
    assign pred_ready     = init_done;
    assign w_accept       = pred_valid & init_done;
    assign pred_out_valid = r_out_valid;
    assign pred_weight    = w_rdata;
    assign pred_taken     = w_rdata[1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT;
            r_sweep     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (w_init) begin
                r_sweep <= r_sweep + bp_index_t'(1);
                if (&r_sweep) r_state <= RUN;
            end
        end
    end
    // The sweep owns the write port during INIT, so training is dropped there.
    rip_bp_counter_ram u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_re     (w_accept),
        .i_raddr  (pred_index),
        .i_we     (w_init | update_valid),
        .i_waddr  (w_init ? r_sweep : update_index),
        .i_wset   (w_init),
        .i_wdata  (INIT_WEIGHT),
        .i_wtaken (update_taken),
        .o_rdata  (w_rdata)
    );
endmodule

// File: tb/tb_rip_bp_counter_table.sv
// tb_rip_bp_counter_table: directed table-driven bench for rip_bp_counter_table
module tb_rip_bp_counter_table;
    import rip_branch_predictor_const::*;
    logic       clk = 1'b0;
    logic       rst;
    logic       pred_valid;
    bp_index_t  pred_index;
    logic       pred_ready;
    logic       pred_out_valid;
    logic       pred_taken;
    bp_weight_t pred_weight;
    logic       update_valid;
    bp_index_t  update_index;
    logic       update_taken;
    logic       init_done;
    int         n_chk = 0;
    int         n_fail = 0;

    rip_bp_counter_table dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_index     (pred_index),
        .pred_ready     (pred_ready),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .pred_weight    (pred_weight),
        .update_valid   (update_valid),
        .update_index   (update_index),
        .update_taken   (update_taken),
        .init_done      (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       uv;
        logic [3:0] ui;
        logic       ut;
        logic       lv;
        logic [3:0] li;
        logic       eov;
        logic [1:0] ew;
    } vec_t;
    vec_t v [12];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    // Table contents after training: 3 saturated up, 5 back to 01, 7 trained to 10,
    // 9 untouched because its updates arrived during INIT.
    function automatic logic [1:0] exp_entry(input int i);
        return (i == 3) ? 2'b11 : (i == 7) ? 2'b10 : 2'b01;
    endfunction

    task automatic wait_init(input string nm);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk1(nm, init_done, k == 16);
            chk1({nm, "_ready"}, pred_ready, k == 16);
            chk1({nm, "_noout"}, pred_out_valid, 1'b0);
        end
    endtask

    task automatic stream(input string nm, input logic all_init);
        for (int i = 0; i < 16; i++) begin
            pred_valid = 1'b1;
            pred_index = bp_index_t'(i);
            @(negedge clk);
            chk1({nm, "_ov"}, pred_out_valid, 1'b1);
            chk2({nm, "_w"}, pred_weight, all_init ? 2'b01 : exp_entry(i));
        end
        pred_valid = 1'b0;
        @(negedge clk);
        chk1({nm, "_ov_end"}, pred_out_valid, 1'b0);
        chk2({nm, "_w_hold"}, pred_weight, all_init ? 2'b01 : exp_entry(15));
    endtask

    initial begin
        v[0]  = '{1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 1'b1, 2'b01};
        v[1]  = '{1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 2'b01};
        v[2]  = '{1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 2'b11};
        v[3]  = '{1'b1, 4'd3, 1'b1, 1'b1, 4'd5, 1'b1, 2'b01};
        v[4]  = '{1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 2'b11};
        v[5]  = '{1'b1, 4'd5, 1'b0, 1'b1, 4'd3, 1'b1, 2'b11};
        v[6]  = '{1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 2'b11};
        v[7]  = '{1'b1, 4'd5, 1'b0, 1'b1, 4'd4, 1'b1, 2'b01};
        v[8]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 2'b00};
        v[9]  = '{1'b1, 4'd5, 1'b1, 1'b1, 4'd6, 1'b1, 2'b01};
        v[10] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 2'b01};
        v[11] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b1, 2'b01};
        rst = 1'b1;
        pred_valid = 1'b0;
        pred_index = '0;
        update_valid = 1'b0;
        update_index = '0;
        update_taken = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_init_done", init_done, 1'b0);
        chk1("rst_ov", pred_out_valid, 1'b0);
        chk1("rst_taken", pred_taken, 1'b0);
        chk2("rst_weight", pred_weight, 2'b00);
        // Lookups and updates held active across INIT must both be ignored.
        pred_valid = 1'b1;
        pred_index = 4'd2;
        update_valid = 1'b1;
        update_index = 4'd9;
        update_taken = 1'b0;
        rst = 1'b0;
        wait_init("init");
        pred_valid = 1'b0;
        update_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            update_valid = v[i].uv;
            update_index = v[i].ui;
            update_taken = v[i].ut;
            pred_valid = v[i].lv;
            pred_index = v[i].li;
            @(negedge clk);
            chk1($sformatf("vec%0d_ov", i), pred_out_valid, v[i].eov);
            chk2($sformatf("vec%0d_w", i), pred_weight, v[i].ew);
            chk1($sformatf("vec%0d_taken", i), pred_taken, v[i].ew[1]);
        end
        update_valid = 1'b0;
        pred_valid = 1'b0;
        @(negedge clk);
        update_valid = 1'b1;
        update_index = 4'd7;
        update_taken = 1'b1;
        pred_valid = 1'b1;
        pred_index = 4'd7;
        @(negedge clk);
        update_valid = 1'b0;
`ifdef BP_FWD_EN
        chk2("collide_fwd", pred_weight, 2'b10);
`else
        chk2("collide_nofwd", pred_weight, 2'b01);
`endif
        @(negedge clk);
        chk2("collide_after", pred_weight, 2'b10);
        chk1("collide_after_taken", pred_taken, 1'b1);
        pred_valid = 1'b0;
        @(negedge clk);
        stream("stream", 1'b0);
        pred_valid = 1'b1;
        pred_index = 4'd3;
        @(negedge clk);
        chk1("pre_abort_ov", pred_out_valid, 1'b1);
        rst = 1'b1;
        pred_valid = 1'b0;
        #1;
        chk1("abort_ov", pred_out_valid, 1'b0);
        chk2("abort_w", pred_weight, 2'b00);
        chk1("abort_init_done", init_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("midinit_init_done", init_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_init("reinit");
        stream("restream", 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
